// File: rtl/servant_proc_loader.sv
// Byte-stream command decoder driving single Wishbone transactions into servant RAM.
// Optional `SERVANT_LOADER_AUTOINC_EN adds the 'N' (write-next) command with an internal address register.
module servant_proc_loader #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_wb_proc_adr,
    output logic [31:0] o_wb_proc_dat,
    output logic [3:0]  o_wb_proc_sel,
    output logic        o_wb_proc_we,
    output logic        o_wb_proc_stb,
    input  logic [31:0] i_wb_proc_rdt,
    input  logic        i_wb_proc_ack
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT < 1) ? '0 : TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          we_q, we_d;
    logic          stb_q, stb_d;
    logic          wr_q, wr_d;
    logic          multi_q, multi_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
`ifdef SERVANT_LOADER_AUTOINC_EN
    logic [31:0]   ainc_q, ainc_d;
`endif

    logic       rx_fire;
    logic       tx_fire;
    logic [1:0] idx_n;

    assign o_rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign rx_fire    = i_rx_valid && o_rx_ready;
    assign tx_fire    = tx_valid_q && i_tx_ready;
    assign idx_n      = idx_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdat_d     = rdat_q;
        we_d       = we_q;
        stb_d      = stb_q;
        wr_d       = wr_q;
        multi_d    = multi_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
`ifdef SERVANT_LOADER_AUTOINC_EN
        ainc_d     = ainc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    case (i_rx_data)
                        8'h57: begin
                            wr_d    = 1'b1;
                            state_d = S_ADDR;
                        end
                        8'h52: begin
                            wr_d    = 1'b0;
                            state_d = S_ADDR;
                        end
`ifdef SERVANT_LOADER_AUTOINC_EN
                        8'h4E: begin
                            wr_d    = 1'b1;
                            adr_d   = ainc_q;
                            state_d = S_DATA;
                        end
`endif
                        default: begin
                            tx_data_d  = 8'h3F;
                            tx_valid_d = 1'b1;
                            multi_d    = 1'b0;
                            idx_d      = 2'd0;
                            state_d    = S_RESP;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    adr_d[{cnt_q, 3'b000} +: 8] = i_rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            stb_d   = 1'b1;
                            we_d    = 1'b0;
                            tmo_d   = '0;
                            state_d = S_BUS;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    dat_d[{cnt_q, 3'b000} +: 8] = i_rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        tmo_d   = '0;
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // ack beats a timeout that expires on the same edge
                if (i_wb_proc_ack) begin
                    stb_d      = 1'b0;
                    we_d       = 1'b0;
                    rdat_d     = i_wb_proc_rdt;
                    tx_valid_d = 1'b1;
                    idx_d      = 2'd0;
                    state_d    = S_RESP;
                    if (wr_q) begin
                        tx_data_d = 8'h4B;
                        multi_d   = 1'b0;
`ifdef SERVANT_LOADER_AUTOINC_EN
                        ainc_d    = adr_q + 32'd4;
`endif
                    end else begin
                        tx_data_d = i_wb_proc_rdt[7:0];
                        multi_d   = 1'b1;
                    end
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    stb_d      = 1'b0;
                    we_d       = 1'b0;
                    tx_data_d  = 8'h54;
                    tx_valid_d = 1'b1;
                    multi_d    = 1'b0;
                    idx_d      = 2'd0;
                    state_d    = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    if (!multi_q || (idx_q == 2'd3)) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        idx_d     = idx_n;
                        tx_data_d = rdat_q[{idx_n, 3'b000} +: 8];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            idx_q      <= 2'd0;
            tmo_q      <= '0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            rdat_q     <= 32'd0;
            we_q       <= 1'b0;
            stb_q      <= 1'b0;
            wr_q       <= 1'b0;
            multi_q    <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
`ifdef SERVANT_LOADER_AUTOINC_EN
            ainc_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdat_q     <= rdat_d;
            we_q       <= we_d;
            stb_q      <= stb_d;
            wr_q       <= wr_d;
            multi_q    <= multi_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
`ifdef SERVANT_LOADER_AUTOINC_EN
            ainc_q     <= ainc_d;
`endif
        end
    end

    assign o_tx_data     = tx_data_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_wb_proc_adr = adr_q;
    assign o_wb_proc_dat = dat_q;
    assign o_wb_proc_sel = 4'hF;
    assign o_wb_proc_we  = we_q;
    assign o_wb_proc_stb = stb_q;

endmodule

// File: tb/tb_servant_proc_loader.sv
// Directed bench for servant_proc_loader with a servant-RAM-like responder (ack delay configurable).
module tb_servant_proc_loader;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic [31:0] o_wb_proc_adr;
    logic [31:0] o_wb_proc_dat;
    logic [3:0]  o_wb_proc_sel;
    logic        o_wb_proc_we;
    logic        o_wb_proc_stb;
    logic [31:0] i_wb_proc_rdt;
    logic        i_wb_proc_ack;

    int n_vec = 0;
    int n_err = 0;

    always #5 wb_clk = ~wb_clk;

    servant_proc_loader #(.TIMEOUT(8)) u_dut (
        .wb_clk        (wb_clk),
        .wb_rst        (wb_rst),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_rx_ready    (o_rx_ready),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_wb_proc_adr (o_wb_proc_adr),
        .o_wb_proc_dat (o_wb_proc_dat),
        .o_wb_proc_sel (o_wb_proc_sel),
        .o_wb_proc_we  (o_wb_proc_we),
        .o_wb_proc_stb (o_wb_proc_stb),
        .i_wb_proc_rdt (i_wb_proc_rdt),
        .i_wb_proc_ack (i_wb_proc_ack)
    );

    // responder: acks after ack_delay strobe cycles when ack_en, records each strobe
    logic [31:0] mem [64];
    int          scnt = 0;
    int          ack_delay = 1;
    bit          ack_en = 1'b1;
    int          stb_cycles = 0;
    int          txn_cnt = 0;
    logic        stb_prev;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;

    always @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            i_wb_proc_ack <= 1'b0;
            scnt          <= 0;
            stb_prev      <= 1'b0;
        end else begin
            stb_prev <= o_wb_proc_stb;
            if (o_wb_proc_stb) stb_cycles <= stb_cycles + 1;
            if (o_wb_proc_stb && !stb_prev) begin
                txn_cnt <= txn_cnt + 1;
                cap_adr <= o_wb_proc_adr;
                cap_dat <= o_wb_proc_dat;
                cap_we  <= o_wb_proc_we;
                cap_sel <= o_wb_proc_sel;
            end
            if (o_wb_proc_stb && !i_wb_proc_ack) begin
                scnt <= scnt + 1;
                if (ack_en && (scnt + 1 == ack_delay)) begin
                    i_wb_proc_ack <= 1'b1;
                    i_wb_proc_rdt <= mem[o_wb_proc_adr[7:2]];
                    if (o_wb_proc_we) mem[o_wb_proc_adr[7:2]] <= o_wb_proc_dat;
                end
            end else begin
                i_wb_proc_ack <= 1'b0;
                scnt          <= 0;
            end
        end
    end

    logic [7:0] rx_bytes [8];
    int         rx_n;
    int         first_at;
    int         base_txn;
    int         base_stb;

    // called at a negedge; returns at the negedge after the byte is taken
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && n < 50) begin
            @(negedge wb_clk);
            n++;
        end
        if (!o_rx_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_byte: rx_ready still 0 after %0d cycles, required 1", n);
        end
        @(negedge wb_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic collect(input bit toggle);
        rx_n     = 0;
        first_at = -1;
        for (int i = 0; i < 30; i++) begin
            if (toggle) i_tx_ready = i[0];
            if (o_tx_valid && i_tx_ready) begin
                if (first_at < 0) first_at = i;
                if (rx_n < 8) rx_bytes[rx_n] = o_tx_data;
                rx_n++;
            end
            @(negedge wb_clk);
        end
        i_tx_ready = 1'b1;
    endtask

    task automatic mark;
        base_txn = txn_cnt;
        base_stb = stb_cycles;
    endtask

    task automatic test_reset;
        #1;
        n_vec++; if (o_wb_proc_stb !== 1'b0) begin n_err++; $display("FAIL reset_stb: got %b want 0", o_wb_proc_stb); end
        n_vec++; if (o_wb_proc_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", o_wb_proc_we); end
        n_vec++; if (o_wb_proc_adr !== 32'h0) begin n_err++; $display("FAIL reset_adr: got %h want 0", o_wb_proc_adr); end
        n_vec++; if (o_wb_proc_dat !== 32'h0) begin n_err++; $display("FAIL reset_dat: got %h want 0", o_wb_proc_dat); end
        n_vec++; if (o_wb_proc_sel !== 4'hF) begin n_err++; $display("FAIL reset_sel: got %h want F", o_wb_proc_sel); end
        n_vec++; if (o_tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", o_tx_valid); end
        n_vec++; if (o_tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", o_tx_data); end
        n_vec++; if (o_rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", o_rx_ready); end
        @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);
    endtask

    task automatic test_write;
        mark();
        send_byte(8'h57);
        send_word(32'h0000_0010);
        send_word(32'hDEAD_BEEF);
        collect(1'b0);
        n_vec++; if (rx_n !== 1) begin n_err++; $display("FAIL write_resp_count: got %0d want 1", rx_n); end
        n_vec++; if (rx_bytes[0] !== 8'h4B) begin n_err++; $display("FAIL write_resp: got %h want 4b", rx_bytes[0]); end
        n_vec++; if (first_at !== 2) begin n_err++; $display("FAIL write_latency: got %0d want 2", first_at); end
        n_vec++; if (txn_cnt - base_txn !== 1) begin n_err++; $display("FAIL write_strobes: got %0d want 1", txn_cnt - base_txn); end
        n_vec++; if (stb_cycles - base_stb !== 2) begin n_err++; $display("FAIL write_stb_len: got %0d want 2", stb_cycles - base_stb); end
        n_vec++; if (cap_adr !== 32'h10) begin n_err++; $display("FAIL write_adr: got %h want 10", cap_adr); end
        n_vec++; if (cap_dat !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_dat: got %h want deadbeef", cap_dat); end
        n_vec++; if (cap_we !== 1'b1) begin n_err++; $display("FAIL write_we: got %b want 1", cap_we); end
        n_vec++; if (cap_sel !== 4'hF) begin n_err++; $display("FAIL write_sel: got %h want f", cap_sel); end
    endtask

    task automatic test_read(input bit toggle, input int exp_first);
        logic [31:0] exp_w;
        exp_w = 32'hDEADBEEF;
        mark();
        send_byte(8'h52);
        send_word(32'h0000_0010);
        n_vec++; if (o_rx_ready !== 1'b0) begin n_err++; $display("FAIL read_rx_ready_bus: got %b want 0", o_rx_ready); end
        collect(toggle);
        n_vec++; if (rx_n !== 4) begin n_err++; $display("FAIL read_resp_count(toggle=%0d): got %0d want 4", toggle, rx_n); end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (rx_bytes[k] !== exp_w[8*k +: 8]) begin
                n_err++;
                $display("FAIL read_byte%0d(toggle=%0d): got %h want %h", k, toggle, rx_bytes[k], exp_w[8*k +: 8]);
            end
        end
        if (!toggle) begin
            n_vec++; if (first_at !== exp_first) begin n_err++; $display("FAIL read_latency: got %0d want %0d", first_at, exp_first); end
        end
        n_vec++; if (cap_we !== 1'b0) begin n_err++; $display("FAIL read_we: got %b want 0", cap_we); end
        n_vec++; if (txn_cnt - base_txn !== 1) begin n_err++; $display("FAIL read_strobes: got %0d want 1", txn_cnt - base_txn); end
        n_vec++; if (o_rx_ready !== 1'b1) begin n_err++; $display("FAIL read_rx_ready_idle: got %b want 1", o_rx_ready); end
    endtask

    task automatic test_unknown;
        mark();
        send_byte(8'h00);
        collect(1'b0);
        n_vec++; if (rx_n !== 1) begin n_err++; $display("FAIL unknown_count: got %0d want 1", rx_n); end
        n_vec++; if (rx_bytes[0] !== 8'h3F) begin n_err++; $display("FAIL unknown_resp: got %h want 3f", rx_bytes[0]); end
        n_vec++; if (first_at !== 0) begin n_err++; $display("FAIL unknown_latency: got %0d want 0", first_at); end
        n_vec++; if (txn_cnt - base_txn !== 0) begin n_err++; $display("FAIL unknown_strobes: got %0d want 0", txn_cnt - base_txn); end
        test_read(1'b0, 2);
    endtask

    task automatic test_timeout;
        ack_en = 1'b0;
        mark();
        send_byte(8'h52);
        send_word(32'h0000_0010);
        collect(1'b0);
        ack_en = 1'b1;
        n_vec++; if (rx_n !== 1) begin n_err++; $display("FAIL timeout_count: got %0d want 1", rx_n); end
        n_vec++; if (rx_bytes[0] !== 8'h54) begin n_err++; $display("FAIL timeout_resp: got %h want 54", rx_bytes[0]); end
        n_vec++; if (stb_cycles - base_stb !== 8) begin n_err++; $display("FAIL timeout_stb_len: got %0d want 8", stb_cycles - base_stb); end
        n_vec++; if (first_at !== 8) begin n_err++; $display("FAIL timeout_latency: got %0d want 8", first_at); end
    endtask

    task automatic test_ack_on_timeout_edge;
        ack_delay = 7;
        mark();
        test_read(1'b0, 8);
        ack_delay = 1;
        n_vec++; if (stb_cycles - base_stb !== 8) begin n_err++; $display("FAIL edge_stb_len: got %0d want 8", stb_cycles - base_stb); end
    endtask

    task automatic test_reset_mid_command;
        send_byte(8'h57);
        send_byte(8'h30);
        send_byte(8'h00);
        wb_rst = 1'b1;
        #1;
        n_vec++; if (o_wb_proc_stb !== 1'b0) begin n_err++; $display("FAIL midcmd_stb: got %b want 0", o_wb_proc_stb); end
        n_vec++; if (o_rx_ready !== 1'b1) begin n_err++; $display("FAIL midcmd_rx_ready: got %b want 1", o_rx_ready); end
        @(negedge wb_clk);
        wb_rst = 1'b0;
        collect(1'b0);
        n_vec++; if (rx_n !== 0) begin n_err++; $display("FAIL midcmd_no_resp: got %0d bytes want 0", rx_n); end
        mark();
        send_byte(8'h57);
        send_word(32'h0000_0030);
        send_word(32'h1234_5678);
        collect(1'b0);
        n_vec++; if (rx_bytes[0] !== 8'h4B || rx_n !== 1) begin n_err++; $display("FAIL midcmd_rewrite_resp: got %h x%0d want 4b x1", rx_bytes[0], rx_n); end
        n_vec++; if (cap_adr !== 32'h30 || cap_dat !== 32'h12345678) begin n_err++; $display("FAIL midcmd_rewrite_bus: got %h/%h want 30/12345678", cap_adr, cap_dat); end
    endtask

    task automatic test_reset_mid_strobe;
        ack_en = 1'b0;
        send_byte(8'h52);
        send_word(32'h0000_0010);
        @(negedge wb_clk);
        @(negedge wb_clk);
        n_vec++; if (o_wb_proc_stb !== 1'b1) begin n_err++; $display("FAIL midstb_pre: got %b want 1", o_wb_proc_stb); end
        #2;
        wb_rst = 1'b1;
        #1;
        n_vec++; if (o_wb_proc_stb !== 1'b0) begin n_err++; $display("FAIL midstb_async_drop: got %b want 0", o_wb_proc_stb); end
        @(negedge wb_clk);
        wb_rst = 1'b0;
        ack_en = 1'b1;
        collect(1'b0);
        n_vec++; if (rx_n !== 0) begin n_err++; $display("FAIL midstb_no_resp: got %0d bytes want 0", rx_n); end
    endtask

    task automatic test_autoinc;
        mark();
        send_byte(8'h57);
        send_word(32'h0000_0020);
        send_word(32'hAABB_CCDD);
        collect(1'b0);
        n_vec++; if (rx_bytes[0] !== 8'h4B) begin n_err++; $display("FAIL autoinc_w_resp: got %h want 4b", rx_bytes[0]); end
        mark();
        send_byte(8'h4E);
`ifdef SERVANT_LOADER_AUTOINC_EN
        send_word(32'h4433_2211);
        collect(1'b0);
        n_vec++; if (rx_n !== 1 || rx_bytes[0] !== 8'h4B) begin n_err++; $display("FAIL autoinc_n_resp: got %h x%0d want 4b x1", rx_bytes[0], rx_n); end
        n_vec++; if (txn_cnt - base_txn !== 1) begin n_err++; $display("FAIL autoinc_n_strobes: got %0d want 1", txn_cnt - base_txn); end
        n_vec++; if (cap_adr !== 32'h24) begin n_err++; $display("FAIL autoinc_n_adr: got %h want 24", cap_adr); end
        n_vec++; if (cap_dat !== 32'h44332211) begin n_err++; $display("FAIL autoinc_n_dat: got %h want 44332211", cap_dat); end
        n_vec++; if (cap_we !== 1'b1) begin n_err++; $display("FAIL autoinc_n_we: got %b want 1", cap_we); end
`else
        collect(1'b0);
        n_vec++; if (rx_n !== 1 || rx_bytes[0] !== 8'h3F) begin n_err++; $display("FAIL n_unknown_resp: got %h x%0d want 3f x1", rx_bytes[0], rx_n); end
        n_vec++; if (txn_cnt - base_txn !== 0) begin n_err++; $display("FAIL n_unknown_strobes: got %0d want 0", txn_cnt - base_txn); end
`endif
    endtask

    initial begin
        @(negedge wb_clk);
        test_reset();
        test_write();
        test_read(1'b0, 2);
        test_read(1'b1, 2);
        test_unknown();
        test_timeout();
        test_ack_on_timeout_edge();
        test_reset_mid_command();
        test_reset_mid_strobe();
        test_autoinc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/servant_proc_loader.md
# servant_proc_loader

Byte-stream-driven Wishbone initiator for the servant SoC's external processor port (`i_wb_proc_*` / `o_wb_proc_*`). Decodes simple write/read commands arriving on a byte stream (e.g. from a UART receiver) and issues single Wishbone transactions into servant RAM. Returns status and read data on an outbound byte stream. Used to load program images and inspect memory from a host, without involving the SERV core.

## Interface
- `TIMEOUT`, default 255: cycles to wait for ack before aborting; 0 disables the timeout.
- `wb_clk` in, 1: clock; all logic on the rising edge.
- `wb_rst` in, 1: reset, asynchronous, active-high.
- `i_rx_data` in, 8: command byte.
- `i_rx_valid` in, 1: `i_rx_data` valid.
- `o_rx_ready` out, 1: loader accepts a byte; transfer occurs when valid & ready.
- `o_tx_data` out, 8: response byte.
- `o_tx_valid` out, 1: response byte valid; held with stable data until accepted.
- `i_tx_ready` in, 1: sink accepts the response byte.
- `o_wb_proc_adr` out, 32: Wishbone address; connects to `i_wb_proc_adr`.
- `o_wb_proc_dat` out, 32: write data.
- `o_wb_proc_sel` out, 4: byte select; always 4'hF.
- `o_wb_proc_we` out, 1: write enable.
- `o_wb_proc_stb` out, 1: strobe; this is the cycle signal.
- `i_wb_proc_rdt` in, 32: read data.
- `i_wb_proc_ack` in, 1: single-cycle acknowledge.

## Operation
- **Commands.** Multi-byte fields are little-endian: LSB first.
  - 0x57 'W' + 4 address bytes + 4 data bytes: write word; response 0x4B 'K'.
  - 0x52 'R' + 4 address bytes: read word; response is 4 data bytes, LSB first.
  - Any other opcode: response 0x3F '?'. No bus access. Next byte is treated as an opcode.
- **Bus timeout.** If ack has not arrived after `TIMEOUT` cycles of strobe, the transaction is abandoned. Response is 0x54 'T' in place of 'K' or the read data.
- **State machine.** States IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: on opcode W or R, go to ADDR. On an unknown opcode, go to RESP with '?'.
  - ADDR: accept 4 bytes. Then W goes to DATA; R goes to BUS.
  - DATA: accept 4 bytes, then go to BUS.
  - BUS: strobe until ack or timeout, then go to RESP.
  - RESP: emit 1 or 4 bytes, then go to IDLE.
- **Counters.** 2-bit byte counter for fields. 2-bit response index. Timeout counter of width $clog2(TIMEOUT+1).
- **Address.** Passed through unmodified; alignment is the responder's concern.
- **Reset values.**
  - State = IDLE.
  - `o_wb_proc_stb`=0, `o_wb_proc_we`=0, `o_wb_proc_adr`=0, `o_wb_proc_dat`=0, `o_wb_proc_sel`=4'hF.
  - `o_tx_valid`=0, `o_tx_data`=0.
  - `o_rx_ready`=1.
- **Reset mid-operation.** Strobe drops asynchronously. The partial command and any pending response are discarded.

## Timing
- **Byte intake.** `o_rx_ready`=1 exactly in IDLE, ADDR and DATA; 0 in BUS and RESP. One byte is accepted per cycle, so back-to-back bytes are allowed.
- **Strobe start.** `o_wb_proc_stb` rises on the edge that accepts the last command byte. `adr`, `dat` and `we` are valid and stable from that cycle until stb falls.
- **Ack handling.** Ack sampled high at an edge: stb and we fall at that same edge, and `i_wb_proc_rdt` is latched there. Stb is never reasserted in the cycle after ack.
- **Response latency.** `o_tx_valid` rises at the edge that ends BUS. With servant RAM (ack one cycle after stb), the first response byte is valid 2 cycles after the final command byte is accepted.
- **Unknown opcode.** '?' is valid the cycle after the opcode is accepted.
- **Timeout.** Stb falls at the edge where the counter reaches `TIMEOUT`, i.e. after exactly `TIMEOUT` strobe cycles. An ack arriving on that same edge wins: the transaction completes normally.
- **Response handshake.** Each response byte advances on tx valid & ready. After the last byte is accepted, the loader is back in IDLE with `o_rx_ready`=1 the next cycle.

## Configuration
- **Macro:** `SERVANT_LOADER_AUTOINC_EN`.
- **Defined:**
  - Every completed W or N command updates an internal address register to the written address + 4.
  - New command 0x4E 'N' + 4 data bytes writes at the internal address; response 'K'.
  - Reads do not change the internal address.
  - The internal address resets to 0.
- **Undefined:** 'N' is an unknown opcode and returns '?'. The address register is not built.

## Test plan
- **Write:** 'W', 10 00 00 00, EF BE AD DE -> one strobe with adr=0x10, dat=0xDEADBEEF, we=1, sel=F -> response 'K'.
- **Read-back:** 'R', 10 00 00 00 -> we=0 strobe -> responses EF, BE, AD, DE. Repeat with `i_tx_ready` toggling every other cycle; bytes must be unchanged and in order, with no duplicates.
- **Unknown opcode:** 0x00 -> '?', no strobe. A following 'R' command executes normally.
- **Timeout:** `TIMEOUT`=8, ack tied low, 'R' command -> stb high for exactly 8 cycles, then low -> 'T' only.
- **Reset mid-command:** assert `wb_rst` after 'W' + 2 address bytes -> stb=0, `o_rx_ready`=1, no response. A new full 'W' command succeeds.
- **Auto-increment (macro on):** 'W' at 0x20, then 'N' 11 22 33 44 -> second strobe adr=0x24, dat=0x44332211. With macro off, 'N' -> '?'.
